// File: rtl/mips_icache_pkg.sv
// rtl/mips_icache_pkg.sv - shared state encoding and geometry helpers for the instruction cache
package mips_icache_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH       = 2'd0,
        ST_LOOKUP      = 2'd1,
        ST_REFILL_REQ  = 2'd2,
        ST_REFILL_DATA = 2'd3
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Fetch addresses are word aligned, so the tag covers what is left of va[31:2].
    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/mips_icache_ram.sv
// rtl/mips_icache_ram.sv - tag, valid and data arrays with synchronous read
module mips_icache_ram
    import mips_icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4,
    parameter int OFF_W = off_w(WORDS),
    parameter int IDX_W = idx_w(LINES),
    parameter int TAG_W = tag_w(LINES, WORDS)
) (
    input  logic             clock,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             data_we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];
    logic [LINES-1:0] valid_q;

    // Array writes and the registered read port (read returns the pre-write contents).
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        rd_tag   <= tag_mem[rd_idx];
        rd_data  <= data_mem[{rd_idx, rd_off}];
        rd_valid <= valid_q[rd_idx];
    end

    // Valid bits: the flush walk clears them, a completed refill sets (or leaves clear) one.
    always_ff @(posedge clock) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (tag_we) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

endmodule

// File: rtl/mips_icache.sv
// rtl/mips_icache.sv - direct-mapped instruction cache; MIPS_ICACHE_CRITICAL_FIRST_EN enables critical-word-first refill
module mips_icache
    import mips_icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] va,
    output logic [31:0] op,
    output logic        ready,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WORDS);
    localparam logic [OFF_W-1:0] OFF_ONE    = OFF_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(LINES - 1);
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
    // The critical word was already forwarded, so the core has moved on to a new va.
    localparam bit RELOOK = 1'b0;
`else
    localparam bit RELOOK = 1'b1;
`endif

    state_t           state_q;
    logic [31:2]      va_q;
    logic [IDX_W-1:0] flush_q;
    logic [OFF_W-1:0] beat_q;
    logic             lkp_q, relook_q, inv_pend_q, mem_req_q;
    logic [31:0]      mem_addr_q;
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
    logic             first_q;
`endif

    logic [31:2]      lk_va;
    logic [OFF_W-1:0] q_off, start_off;
    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag, rd_tag;
    logic [31:0]      rd_data, refill_addr;
    logic             rd_valid, hit, beat_we, last_beat;
    logic             unused_va;

    assign unused_va = ^va[1:0];
    // After a refill the held address is looked up again instead of the live va.
    assign lk_va     = relook_q ? va_q : va[31:2];
    assign q_off     = va_q[OFF_W+1:2];
    assign q_idx     = va_q[OFF_W+IDX_W+1:OFF_W+2];
    assign q_tag     = va_q[31:OFF_W+IDX_W+2];
    assign hit       = lkp_q && rd_valid && (rd_tag == q_tag);
    assign beat_we   = (state_q == ST_REFILL_DATA) && mem_valid;
    assign last_beat = (beat_q + OFF_ONE) == start_off;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
    assign start_off   = q_off;
    assign refill_addr = {va_q[31:2], 2'b00};
`else
    assign start_off   = '0;
    assign refill_addr = {va_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
`endif

    mips_icache_ram #(.LINES(LINES), .WORDS(WORDS)) u_ram (
        .clock    (clock),
        .rd_idx   (lk_va[OFF_W+IDX_W+1:OFF_W+2]),
        .rd_off   (lk_va[OFF_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (beat_we),
        .wr_idx   (q_idx),
        .wr_off   (beat_q),
        .wr_data  (mem_data),
        .tag_we   (beat_we && last_beat),
        .wr_tag   (q_tag),
        .wr_valid (!(inv_pend_q || inv)),
        .clr_en   (state_q == ST_FLUSH),
        .clr_idx  (flush_q)
    );

    // Hit data straight from the registered read; optionally the forwarded critical beat.
    always_comb begin
        ready = (state_q == ST_LOOKUP) && hit;
        op    = ready ? rd_data : '0;
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
        if (beat_we && first_q) begin
            ready = 1'b1;
            op    = mem_data;
        end
`endif
    end

    // Control FSM: flush walk, lookup, refill request and beat collection.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FLUSH;
            flush_q    <= '0;
            beat_q     <= '0;
            va_q       <= '0;
            lkp_q      <= 1'b0;
            relook_q   <= 1'b0;
            inv_pend_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
            first_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (inv) begin
                        flush_q <= '0;
                    end else if (flush_q == FLUSH_LAST) begin
                        flush_q <= '0;
                        state_q <= ST_LOOKUP;
                    end else begin
                        flush_q <= flush_q + IDX_ONE;
                    end
                end
                ST_LOOKUP: begin
                    if (inv) begin
                        state_q  <= ST_FLUSH;
                        flush_q  <= '0;
                        lkp_q    <= 1'b0;
                        relook_q <= 1'b0;
                    end else if (lkp_q && !hit) begin
                        state_q    <= ST_REFILL_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= refill_addr;
                        lkp_q      <= 1'b0;
                        inv_pend_q <= 1'b0;
                    end else begin
                        va_q     <= lk_va;
                        lkp_q    <= 1'b1;
                        relook_q <= 1'b0;
                    end
                end
                ST_REFILL_REQ: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_REFILL_DATA;
                        beat_q    <= start_off;
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
                        first_q   <= 1'b1;
`endif
                    end
                end
                ST_REFILL_DATA: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (mem_valid) begin
                        beat_q <= beat_q + OFF_ONE;
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
                        first_q <= 1'b0;
`endif
                        if (last_beat) begin
                            inv_pend_q <= 1'b0;
                            if (inv_pend_q || inv) begin
                                state_q <= ST_FLUSH;
                                flush_q <= '0;
                            end else begin
                                state_q  <= ST_LOOKUP;
                                relook_q <= RELOOK;
                            end
                        end
                    end
                end
                default: state_q <= ST_FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_icache.sv
// tb/tb_mips_icache.sv - self-checking bench for mips_icache (directed table plus randomized model check)
module tb_mips_icache;

    logic        clock = 1'b0;
    logic        reset, inv, mem_ack, mem_valid, ready, mem_req;
    logic [31:0] va, op, mem_addr, mem_data;
    int          vectors     = 0;
    int          miscompares = 0;

    typedef struct {
        logic [31:0]  va;
        bit           hit;
        logic [127:0] line;
    } vec_t;

    vec_t         tbl [8];
    bit           mvalid [64];
    logic [21:0]  mtag [64];

    always #5 clock = ~clock;

    mips_icache #(.LINES(64), .WORDS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .va        (va),
        .op        (op),
        .ready     (ready),
        .inv       (inv),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_data  (mem_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [127:0] memline(input logic [31:0] base);
        return {hashf(base + 32'd12), hashf(base + 32'd8), hashf(base + 32'd4), hashf(base)};
    endfunction

    // A full flush: 64 cycles with the core stalled and no memory traffic.
    task automatic flush_wait(input string name);
        for (int i = 0; i < 64; i++) begin
            tick();
            check({name, "_ready"}, 32'(ready), 32'd0);
            check({name, "_req"}, 32'(mem_req), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_req", 32'(mem_req), 32'd0);
        check("reset_op", op, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        flush_wait("flush");
    endtask

    // One fetch; on a miss serve the refill from 'line' and check the restart.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [127:0] line,
                         input int ack_dly, input int gap, input int inv_beat);
        int          off;
        int          w;
        logic [31:0] exp_op;
        off    = int'(a[3:2]);
        exp_op = line[32*off +: 32];
        va = a;
        tick();
        if (exp_hit) begin
            check("hit_ready", 32'(ready), 32'd1);
            check("hit_op", op, exp_op);
        end else begin
            check("miss_ready", 32'(ready), 32'd0);
            check("miss_req_early", 32'(mem_req), 32'd0);
            tick();
            check("req", 32'(mem_req), 32'd1);
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
            check("req_addr", mem_addr, {a[31:2], 2'b00});
`else
            check("req_addr", mem_addr, {a[31:4], 4'b0000});
`endif
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                check("req_hold", 32'(mem_req), 32'd1);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("req_drop", 32'(mem_req), 32'd0);
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_ready", 32'(ready), 32'd0);
                end
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
                w = (off + k) % 4;
`else
                w = k;
`endif
                mem_valid = 1'b1;
                mem_data  = line[32*w +: 32];
                inv       = (k == inv_beat);
`ifdef MIPS_ICACHE_CRITICAL_FIRST_EN
                #1;
                check("fwd_ready", 32'(ready), (k == 0) ? 32'd1 : 32'd0);
                if (k == 0) check("fwd_op", op, exp_op);
`endif
                tick();
                mem_valid = 1'b0;
                inv       = 1'b0;
            end
            check("fill_ready", 32'(ready), 32'd0);
            if (inv_beat >= 0) begin
                flush_wait("inv_flush");
            end else begin
                tick();
                check("fill_ready1", 32'(ready), 32'd1);
                check("fill_op", op, exp_op);
            end
        end
    endtask

    initial begin
        reset = 1'b0; inv = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0;
        mem_data = '0; va = '0;

        tbl[0] = '{va: 32'h104, hit: 1'b0, line: mkline(32'hA0)};
        tbl[1] = '{va: 32'h100, hit: 1'b1, line: mkline(32'hA0)};
        tbl[2] = '{va: 32'h108, hit: 1'b1, line: mkline(32'hA0)};
        tbl[3] = '{va: 32'h10C, hit: 1'b1, line: mkline(32'hA0)};
        tbl[4] = '{va: 32'h504, hit: 1'b0, line: mkline(32'hB0)};
        tbl[5] = '{va: 32'h104, hit: 1'b0, line: mkline(32'hA0)};
        tbl[6] = '{va: 32'h50C, hit: 1'b0, line: mkline(32'hB0)};
        tbl[7] = '{va: 32'h500, hit: 1'b1, line: mkline(32'hB0)};

        do_reset();
        fetch(32'h0, 1'b0, mkline(32'hE0), 0, 0, -1);
        for (int i = 0; i < 8; i++) begin
            fetch(tbl[i].va, tbl[i].hit, tbl[i].line, 1, 0, -1);
        end

        // Slow memory, gapped beats and an invalidate landing mid-refill.
        fetch(32'h2008, 1'b0, mkline(32'hC0), 5, 2, 2);
        fetch(32'h504, 1'b0, mkline(32'hB0), 0, 0, -1);
        fetch(32'h508, 1'b1, mkline(32'hB0), 0, 0, -1);

        // Invalidate while idle in lookup.
        inv = 1'b1;
        tick();
        inv = 1'b0;
        check("inv_ready", 32'(ready), 32'd0);
        flush_wait("inv_lookup_flush");
        fetch(32'h504, 1'b0, mkline(32'hB0), 0, 1, -1);

        // Reset while a refill request is outstanding.
        va = 32'h700;
        tick();
        tick();
        check("abort_req_before", 32'(mem_req), 32'd1);
        do_reset();

        // Randomized fetches against a direct-mapped reference model.
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          idx;
            int          ib;
            bit          h;
            a   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            idx = int'(a[9:4]);
            h   = mvalid[idx] && (mtag[idx] == a[31:10]);
            ib  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, h, memline({a[31:4], 4'b0000}), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), h ? -1 : ib);
            if (!h) begin
                if (ib >= 0) begin
                    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
                end else begin
                    mvalid[idx] = 1'b1;
                    mtag[idx]   = a[31:10];
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
